fetch_stage: RTL

Instruction-fetch stage of the 5-stage ARM-subset pipeline. It owns the PC register and drives the word-addressed instruction memory with a byte address. The memory's combinational read data is captured, with the next-sequential PC, into the IF/ID pipeline register feeding decode. It honours hazard freezes and EXE-stage branch redirects, and keeps a delivered-instruction counter for bench and performance checks.

---
 rtl/pipeline_pkg.sv | 16 +
 rtl/if_id_reg.sv | 30 +++
 rtl/fetch_stage.sv | 75 +++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared pipeline constants and the IF/ID bundle
package pipeline_pkg;

  localparam int          WORD_BYTES       = 4;
  localparam int          PC_W             = 32;
  localparam int          INSTR_W          = 32;
  localparam logic [31:0] BUBBLE_INSTR     = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
    logic               valid;
  } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register; flush overrides freeze
module if_id_reg
  import pipeline_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               freeze,
  input  logic               flush,
  input  logic [PC_W-1:0]    d_pc,
  input  logic [INSTR_W-1:0] d_instr,
  input  logic               d_valid,
  output logic [PC_W-1:0]    q_pc,
  output logic [INSTR_W-1:0] q_instr,
  output logic               q_valid
);

  // A squashed wrong-path slot must never survive a stall, so flush is checked first.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      q_pc    <= '0;
      q_instr <= BUBBLE_INSTR;
      q_valid <= 1'b0;
    end else if (!freeze) begin
      q_pc    <= d_pc;
      q_instr <= d_instr;
      q_valid <= d_valid;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch: PC register, next-PC mux, IF/ID capture, fetch counter
module fetch_stage
  import pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int          IMEM_DEPTH = 128,
  parameter int          CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 freeze,
  input  logic                 branch_taken,
  input  logic [31:0]          branch_addr,
  output logic [31:0]          imem_addr,
  input  logic [31:0]          imem_instr,
  output logic [31:0]          if_pc,
  output logic [31:0]          if_instr,
  output logic                 if_valid,
  output logic [CNT_WIDTH-1:0] fetch_count
);

  localparam logic [31:0]          IMEM_BYTES = 32'(IMEM_DEPTH * WORD_BYTES);
  localparam logic [31:0]          WORD_MASK  = ~32'(WORD_BYTES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;

  logic [31:0] pc;
  logic [31:0] pc_next;
  logic [31:0] pc_plus4;
  logic [31:0] fetch_instr;
  logic        in_range;
  logic        load;

  assign imem_addr   = pc;
  assign pc_plus4    = pc + 32'(WORD_BYTES);
  assign in_range    = (pc < IMEM_BYTES);
  assign load        = !branch_taken && !freeze;
  assign fetch_instr = in_range ? imem_instr : BUBBLE_INSTR;

  // Running off the end of memory parks the PC until a branch or reset.
  always_comb begin
    pc_next = pc;
    if (branch_taken)
      pc_next = branch_addr & WORD_MASK;
    else if (!freeze && in_range)
      pc_next = pc_plus4;
  end

  always_ff @(posedge clk) begin
    if (rst)
      pc <= RESET_PC;
    else
      pc <= pc_next;
  end

  always_ff @(posedge clk) begin
    if (rst)
      fetch_count <= '0;
    else if (load && in_range && fetch_count != CNT_MAX)
      fetch_count <= fetch_count + 1'b1;
  end

  if_id_reg u_if_id (
    .clk     (clk),
    .rst     (rst),
    .freeze  (freeze),
    .flush   (branch_taken),
    .d_pc    (pc_plus4),
    .d_instr (fetch_instr),
    .d_valid (in_range),
    .q_pc    (if_pc),
    .q_instr (if_instr),
    .q_valid (if_valid)
  );

endmodule
